// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, default geometry, byte lanes.
package lsu_pkg;

    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned MEM_DEPTH_DEF = 1024;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned LANE0_LSB = 0;
    localparam int unsigned LANE1_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_byte_merge.sv
// Byte-lane extraction with zero/sign extension for loads, and lane replacement for byte stores.
module lsu_byte_merge
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_lane,
    input  logic              i_is_byte,
    input  logic              i_signed,
    input  logic [LANE_W-1:0] i_byte,
    output logic [DATA_W-1:0] o_load_data,
    output logic [DATA_W-1:0] o_merged
);

    logic [LANE_W-1:0] w_lane_byte;

    assign w_lane_byte = i_lane ? i_word[LANE1_LSB +: LANE_W] : i_word[LANE0_LSB +: LANE_W];

    always_comb begin
        o_load_data = i_word;
        if (i_is_byte) begin
            o_load_data = {{(DATA_W-LANE_W){i_signed & w_lane_byte[LANE_W-1]}}, w_lane_byte};
        end
        o_merged = i_word;
        if (i_lane) begin
            o_merged[LANE1_LSB +: LANE_W] = i_byte;
        end else begin
            o_merged[LANE0_LSB +: LANE_W] = i_byte;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word/byte access to a word-addressed data memory.
// Define LSU_ALIGN_CHECK_EN to reject word accesses with an odd byte address.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_rd,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [2:0]        rsp_rd,
    output logic              rsp_is_load,
    output logic              rsp_err
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_next;
    logic              r_is_load;
    logic              r_byte;
    logic              r_signed;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word;
    logic [2:0]        r_rd;

    logic              w_accept;
    logic [31:0]       w_idx_ext;
    logic              w_oob;
    logic              w_misalign;
    logic              w_req_err;
    logic [ADDR_W-1:0] w_mem_idx;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_merged;

    assign w_accept  = req_valid & req_ready;
    assign w_idx_ext = 32'(req_addr[ADDR_W-1:1]);
    assign w_oob     = w_idx_ext >= MEM_DEPTH;
`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ~req_byte & req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif
    assign w_req_err = w_oob | w_misalign;
    assign w_mem_idx = {1'b0, r_addr[ADDR_W-1:1]};

    lsu_byte_merge #(
        .DATA_W (DATA_W)
    ) u_byte_merge (
        .i_word      (r_word),
        .i_lane      (r_addr[0]),
        .i_is_byte   (r_byte),
        .i_signed    (r_signed),
        .i_byte      (r_wdata[LANE_W-1:0]),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_is_load <= 1'b0;
            r_byte    <= 1'b0;
            r_signed  <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_word    <= '0;
            r_rd      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_is_load <= ~req_write;
                r_byte    <= req_byte;
                r_signed  <= req_signed;
                r_err     <= w_req_err;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_rd      <= req_rd;
            end
            if (r_state == LOAD || r_state == RMW_RD) begin
                r_word <= mem_read_data;
            end
        end
    end

    // Outputs decode from state only, so every strobe is zero in IDLE and RESP.
    always_comb begin
        w_state_next   = r_state;
        req_ready      = (r_state == IDLE) && !reset;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_rd         = '0;
        rsp_is_load    = 1'b0;
        rsp_err        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_next = RESP;
                    end else if (!req_write) begin
                        w_state_next = LOAD;
                    end else if (req_byte) begin
                        w_state_next = RMW_RD;
                    end else begin
                        w_state_next = STORE;
                    end
                end
            end
            LOAD: begin
                mem_read     = 1'b1;
                mem_address  = w_mem_idx;
                w_state_next = RESP;
            end
            STORE: begin
                mem_write      = 1'b1;
                mem_address    = w_mem_idx;
                mem_write_data = r_wdata;
                w_state_next   = RESP;
            end
            RMW_RD: begin
                mem_read     = 1'b1;
                mem_address  = w_mem_idx;
                w_state_next = RMW_WR;
            end
            RMW_WR: begin
                mem_write      = 1'b1;
                mem_address    = w_mem_idx;
                mem_write_data = w_merged;
                w_state_next   = RESP;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = (r_is_load && !r_err) ? w_load_data : '0;
                rsp_rd      = r_rd;
                rsp_is_load = r_is_load;
                rsp_err     = r_err;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized traffic vs a memory model.
module tb_load_store_unit;

    localparam int CLK_P = 10;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_byte, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_rd;
    logic [15:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write, mem_read;
    logic        rsp_valid, rsp_ready, rsp_is_load, rsp_err;
    logic [15:0] rsp_rdata;
    logic [2:0]  rsp_rd;

    logic [15:0] mem     [0:DEPTH-1];
    logic [15:0] ref_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_pass   = 0;

    // Observed transaction
    int          obs_lat, obs_nrd, obs_nwr;
    logic [15:0] obs_rdata, obs_waddr, obs_wdata;
    logic [2:0]  obs_rd;
    logic        obs_err, obs_load, obs_bad, obs_stable, obs_released, obs_timeout;
    time         t_acc;

    // Expected transaction
    int          exp_lat, exp_nrd, exp_nwr;
    logic [15:0] exp_rdata, exp_waddr, exp_wdata;
    logic        exp_err;

    always #(CLK_P/2) clk = ~clk;

    assign mem_read_data = (mem_address < 16'(DEPTH)) ? mem[mem_address[9:0]] : 16'h0;

    always @(posedge clk) begin
        if (mem_write && mem_address < 16'(DEPTH)) mem[mem_address[9:0]] <= mem_write_data;
    end

    load_store_unit #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_rd         (rsp_rd),
        .rsp_is_load    (rsp_is_load),
        .rsp_err        (rsp_err)
    );

    // Reference behaviour from the architectural rules, using word-array arithmetic.
    task automatic model_req(input logic w, input logic b, input logic s,
                             input logic [15:0] a, input logic [15:0] d);
        int idx, word, lane_val, dv;
        idx = int'(a) / 2;
        dv  = int'(d);
        exp_err = (idx >= DEPTH);
`ifdef LSU_ALIGN_CHECK_EN
        if (!b && (int'(a) % 2 == 1)) exp_err = 1'b1;
`endif
        exp_rdata = 16'h0; exp_nrd = 0; exp_nwr = 0; exp_waddr = 16'h0; exp_wdata = 16'h0;
        if (exp_err) begin
            exp_lat = 1;
        end else begin
            word     = int'(ref_mem[idx]);
            lane_val = (int'(a) % 2 == 1) ? word / 256 : word % 256;
            if (!w) begin
                exp_lat = 2; exp_nrd = 1;
                if (!b)                        exp_rdata = 16'(word);
                else if (s && lane_val >= 128) exp_rdata = 16'(lane_val + 65280);
                else                           exp_rdata = 16'(lane_val);
            end else if (!b) begin
                exp_lat = 2; exp_nwr = 1;
                ref_mem[idx] = d;
                exp_waddr = 16'(idx); exp_wdata = d;
            end else begin
                exp_lat = 3; exp_nrd = 1; exp_nwr = 1;
                if (int'(a) % 2 == 1) word = (word % 256) + (dv % 256) * 256;
                else                  word = (word / 256) * 256 + dv % 256;
                ref_mem[idx] = 16'(word);
                exp_waddr = 16'(idx); exp_wdata = 16'(word);
            end
        end
    endtask

    // Drives one request starting at a falling edge; records what the DUT did.
    task automatic run_req(input logic w, input logic b, input logic s, input logic [15:0] a,
                           input logic [15:0] d, input logic [2:0] rd, input int delay);
        obs_timeout = 1'b0; obs_bad = 1'b0; obs_stable = 1'b1; obs_released = 1'b0;
        obs_nrd = 0; obs_nwr = 0; obs_lat = 0; obs_waddr = 16'h0; obs_wdata = 16'h0;
        obs_rdata = 16'h0; obs_err = 1'b0; obs_rd = 3'd0; obs_load = 1'b0;
        req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
        req_addr = a; req_wdata = d; req_rd = rd;
        rsp_ready = (delay == 0);
        for (int k = 0; k < 8 && !req_ready; k++) @(negedge clk);
        if (!req_ready) obs_timeout = 1'b1;
        if (!obs_timeout) begin
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
            req_valid = 1'b0;
            obs_lat = 1;
            while (!rsp_valid && obs_lat < 8) begin
                if (mem_read) obs_nrd++;
                if (mem_write) begin
                    obs_nwr++; obs_waddr = mem_address; obs_wdata = mem_write_data;
                end
                if (mem_read && mem_write) obs_bad = 1'b1;
                @(negedge clk);
                obs_lat++;
            end
            if (!rsp_valid) begin
                obs_timeout = 1'b1;
            end else begin
                if (mem_read || mem_write) obs_bad = 1'b1;
                obs_rdata = rsp_rdata; obs_err = rsp_err; obs_rd = rsp_rd; obs_load = rsp_is_load;
                for (int i = 0; i < delay; i++) begin
                    @(negedge clk);
                    if (rsp_rdata !== obs_rdata || rsp_err !== obs_err || rsp_rd !== obs_rd ||
                        rsp_is_load !== obs_load || rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                        mem_read !== 1'b0 || mem_write !== 1'b0) obs_stable = 1'b0;
                end
                rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                obs_released = (rsp_valid === 1'b0) && (req_ready === 1'b1);
                rsp_ready = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; req_rd = 3'd0; rsp_ready = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, rsp_valid, rsp_err, rsp_rdata, mem_address, mem_write_data,
             rsp_rd, rsp_is_load, req_ready} !== 57'h0)
            $display("FAIL reset_outputs: got %h expected 0", {mem_read, mem_write, rsp_valid,
                     rsp_err, rsp_rdata, mem_address, mem_write_data, rsp_rd, rsp_is_load, req_ready});
        else n_pass++;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_preload;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            model_req(1'b1, 1'b0, 1'b0, 16'(2 * i), d);
            run_req(1'b1, 1'b0, 1'b0, 16'(2 * i), d, 3'(i), 0);
            n_checks++;
            if ({obs_timeout, obs_nwr, obs_waddr, obs_wdata} !== {1'b0, exp_nwr, exp_waddr, exp_wdata})
                $display("FAIL preload_%0d: got n=%0d a=%h d=%h expected n=%0d a=%h d=%h", i,
                         obs_nwr, obs_waddr, obs_wdata, exp_nwr, exp_waddr, exp_wdata);
            else n_pass++;
        end
    endtask

    task automatic test_word_store_load;
        model_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
        run_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 3'd2, 0);
        n_checks++;
        if ({obs_nwr, obs_nrd, obs_waddr, obs_wdata, obs_lat} !== {32'd1, 32'd0, 16'h0008, 16'hBEEF, 32'd2})
            $display("FAIL word_store: got nwr=%0d nrd=%0d a=%h d=%h lat=%0d expected 1 0 0008 beef 2",
                     obs_nwr, obs_nrd, obs_waddr, obs_wdata, obs_lat);
        else n_pass++;
        n_checks++;
        if ({obs_rdata, obs_err, obs_load, obs_rd} !== {16'h0, 1'b0, 1'b0, 3'd2})
            $display("FAIL word_store_rsp: got %h/%b/%b/%0d expected 0000/0/0/2",
                     obs_rdata, obs_err, obs_load, obs_rd);
        else n_pass++;
        model_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 3'd5, 0);
        n_checks++;
        if ({obs_rdata, obs_lat, obs_nrd, obs_nwr, obs_load, obs_rd} !==
            {16'hBEEF, 32'd2, 32'd1, 32'd0, 1'b1, 3'd5})
            $display("FAIL word_load: got d=%h lat=%0d nrd=%0d nwr=%0d ld=%b rd=%0d expected beef 2 1 0 1 5",
                     obs_rdata, obs_lat, obs_nrd, obs_nwr, obs_load, obs_rd);
        else n_pass++;
    endtask

    task automatic test_byte_store;
        model_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00A5);
        run_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'h00A5, 3'd1, 0);
        n_checks++;
        if ({obs_lat, obs_nrd, obs_nwr, obs_waddr, obs_wdata, obs_bad} !==
            {32'd3, 32'd1, 32'd1, 16'h0008, 16'hA5EF, 1'b0})
            $display("FAIL byte_store: got lat=%0d nrd=%0d nwr=%0d a=%h d=%h bad=%b expected 3 1 1 0008 a5ef 0",
                     obs_lat, obs_nrd, obs_nwr, obs_waddr, obs_wdata, obs_bad);
        else n_pass++;
        n_checks++;
        if (mem[8] !== ref_mem[8]) $display("FAIL byte_store_mem: got %h expected %h", mem[8], ref_mem[8]);
        else n_pass++;
    endtask

    task automatic test_byte_load_sign;
        model_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80EF);
        run_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80EF, 3'd0, 0);
        run_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0, 3'd3, 0);
        n_checks++;
        if (obs_rdata !== 16'hFF80) $display("FAIL byte_load_signed: got %h expected ff80", obs_rdata);
        else n_pass++;
        run_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0, 3'd3, 0);
        n_checks++;
        if (obs_rdata !== 16'h0080) $display("FAIL byte_load_unsigned: got %h expected 0080", obs_rdata);
        else n_pass++;
        run_req(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0, 3'd3, 0);
        n_checks++;
        if (obs_rdata !== 16'hFFEF) $display("FAIL byte_load_lane0: got %h expected ffef", obs_rdata);
        else n_pass++;
    endtask

    task automatic test_error;
        logic [15:0] addrs [3];
        logic        wr    [3];
        addrs[0] = 16'h0800; wr[0] = 1'b0;
        addrs[1] = 16'hFFFF; wr[1] = 1'b1;
        addrs[2] = 16'h0003; wr[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            model_req(wr[i], 1'b0, 1'b0, addrs[i], 16'h1234);
            run_req(wr[i], 1'b0, 1'b0, addrs[i], 16'h1234, 3'd6, 0);
            n_checks++;
            if ({obs_timeout, obs_err, obs_rdata, obs_nrd, obs_nwr} !==
                {1'b0, exp_err, exp_rdata, exp_nrd, exp_nwr})
                $display("FAIL error_%0d: got to=%b err=%b d=%h nrd=%0d nwr=%0d expected 0 %b %h %0d %0d",
                         i, obs_timeout, obs_err, obs_rdata, obs_nrd, obs_nwr,
                         exp_err, exp_rdata, exp_nrd, exp_nwr);
            else n_pass++;
            n_checks++;
            if (exp_err ? (obs_lat > 2) : (obs_lat != exp_lat))
                $display("FAIL error_lat_%0d: got %0d expected %0d", i, obs_lat, exp_lat);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        model_req(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, 3'd7, 4);
        n_checks++;
        if ({obs_stable, obs_released, obs_rdata, obs_rd} !== {1'b1, 1'b1, exp_rdata, 3'd7})
            $display("FAIL backpressure: got st=%b rel=%b d=%h rd=%0d expected 1 1 %h 7",
                     obs_stable, obs_released, obs_rdata, obs_rd, exp_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        time t0, t1, t2;
        model_req(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0, 3'd1, 0);
        t0 = t_acc;
        model_req(1'b1, 1'b1, 1'b0, 16'h0007, 16'h005A);
        run_req(1'b1, 1'b1, 1'b0, 16'h0007, 16'h005A, 3'd2, 0);
        t1 = t_acc;
        model_req(1'b1, 1'b0, 1'b0, 16'h0008, 16'h7777);
        run_req(1'b1, 1'b0, 1'b0, 16'h0008, 16'h7777, 3'd3, 0);
        t2 = t_acc;
        n_checks++;
        if (t1 - t0 !== 3 * CLK_P) $display("FAIL b2b_load: got %0t expected %0d", t1 - t0, 3 * CLK_P);
        else n_pass++;
        n_checks++;
        if (t2 - t1 !== 4 * CLK_P) $display("FAIL b2b_bstore: got %0t expected %0d", t2 - t1, 4 * CLK_P);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 16'h0013; req_wdata = 16'h00C3; req_rd = 3'd4; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (mem_read !== 1'b1) $display("FAIL mid_rmw_read: got %b expected 1", mem_read);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_read, mem_write, rsp_valid, rsp_err, rsp_rdata, mem_address, mem_write_data,
             rsp_rd, rsp_is_load, req_ready} !== 57'h0)
            $display("FAIL mid_reset_outputs: got %h expected 0", {mem_read, mem_write, rsp_valid,
                     rsp_err, rsp_rdata, mem_address, mem_write_data, rsp_rd, rsp_is_load, req_ready});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem[9], req_ready} !== {ref_mem[9], 1'b1})
            $display("FAIL mid_reset_mem: got %h/%b expected %h/1", mem[9], req_ready, ref_mem[9]);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic        w, b, s;
            logic [15:0] a, d;
            logic [2:0]  rd;
            int          dl;
            w  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 31));
            d  = 16'($urandom);
            rd = 3'($urandom);
            dl = int'($urandom_range(0, 2));
            model_req(w, b, s, a, d);
            run_req(w, b, s, a, d, rd, dl);
            n_checks++;
            if ({obs_rdata, obs_err, obs_rd, obs_load} !== {exp_rdata, exp_err, rd, ~w})
                $display("FAIL rand_rsp_%0d: got %h/%b/%0d/%b expected %h/%b/%0d/%b", i,
                         obs_rdata, obs_err, obs_rd, obs_load, exp_rdata, exp_err, rd, ~w);
            else n_pass++;
            n_checks++;
            if ({obs_lat, obs_nrd, obs_nwr} !== {exp_lat, exp_nrd, exp_nwr})
                $display("FAIL rand_timing_%0d: got lat=%0d nrd=%0d nwr=%0d expected %0d %0d %0d", i,
                         obs_lat, obs_nrd, obs_nwr, exp_lat, exp_nrd, exp_nwr);
            else n_pass++;
            n_checks++;
            if ({obs_bad, obs_stable, obs_released, obs_timeout} !== 4'b0110)
                $display("FAIL rand_protocol_%0d: got %b expected 0110", i,
                         {obs_bad, obs_stable, obs_released, obs_timeout});
            else n_pass++;
            if (exp_nwr == 1) begin
                n_checks++;
                if ({obs_waddr, obs_wdata} !== {exp_waddr, exp_wdata})
                    $display("FAIL rand_write_%0d: got %h/%h expected %h/%h", i,
                             obs_waddr, obs_wdata, exp_waddr, exp_wdata);
                else n_pass++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mem[i] !== ref_mem[i]) $display("FAIL mem_final_%0d: got %h expected %h", i, mem[i], ref_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_word_store_load();
        test_byte_store();
        test_byte_load_sign();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
